// File: rtl/axi_clint.sv
// axi_clint: AXI4 slave that holds the machine timer (mtime, mtimecmp).
// It raises a registered timer interrupt (mtip) when mtime >= mtimecmp.
//
// Parameters:
//   BASE_ADDR : byte address of offset 0 (mtime at +0, mtimecmp at +8)
//   TICK_DIV  : mtime advances once every TICK_DIV clocks (>= 1)
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   aw*/w*/b*            : AXI4 write address / data / response channels
//   ar*/r*               : AXI4 read address / data channels
//   mtip                 : machine timer interrupt request (registered)
// Optional feature macro: CLINT_MTIP_EN implements mtimecmp and mtip.
// Without it, offset 8 reads 0, ignores writes, and mtip is tied to 0.
module axi_clint #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   // write address channel
   output logic        awready,
   input  logic        awvalid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   // write data channel
   output logic        wready,
   input  logic        wvalid,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wlast,
   // write response channel
   input  logic        bready,
   output logic        bvalid,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   // read address channel
   output logic        arready,
   input  logic        arvalid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   // read data channel
   input  logic        rready,
   output logic        rvalid,
   output logic [1:0]  rresp,
   output logic [63:0] rdata,
   output logic        rlast,
   output logic [3:0]  rid,
   // interrupt
   output logic        mtip
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic {W_IDLE, W_RESP} w_state_t;

   // ------------------------------------------------------------------
   // Timer
   // ------------------------------------------------------------------
   logic [31:0] presc;
   logic        tick;
   logic [63:0] mtime;

   assign tick = (presc == 32'(TICK_DIV - 1));

   // ------------------------------------------------------------------
   // Write side: AW and W are captured independently
   // ------------------------------------------------------------------
   w_state_t    w_state;
   w_state_t    w_next;
   logic        aw_held;
   logic        w_held;
   logic [31:0] aw_addr_q;
   logic [7:0]  aw_len_q;
   logic [3:0]  aw_id_q;
   logic [63:0] w_data_q;
   logic [7:0]  w_strb_q;

   logic        aw_fire;
   logic        w_fire;
   logic        wl_fire;
   logic        have_aw;
   logic        have_w;
   logic        commit;
   logic [31:0] c_addr;
   logic [31:0] c_off;
   logic [7:0]  c_len;
   logic [3:0]  c_id;
   logic [63:0] c_data;
   logic [7:0]  c_strb;
   logic [63:0] c_mask;
   logic        c_time;
   logic        c_cmp;
   logic        c_ok;
   logic        wr_time;

   assign awready = (w_state == W_IDLE) && !aw_held;
   assign wready  = (w_state == W_IDLE) && !w_held;
   assign bvalid  = (w_state == W_RESP);

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign wl_fire = w_fire && wlast;
   assign have_aw = aw_held || aw_fire;
   assign have_w  = w_held || wl_fire;

   // The second half may arrive this cycle; commit on the same edge.
   assign commit = (w_state == W_IDLE) && have_aw && have_w;

   assign c_addr = aw_held ? aw_addr_q : awaddr;
   assign c_len  = aw_held ? aw_len_q  : awlen;
   assign c_id   = aw_held ? aw_id_q   : awid;
   assign c_data = w_held  ? w_data_q  : wdata;
   assign c_strb = w_held  ? w_strb_q  : wstrb;

   assign c_off  = c_addr - BASE_ADDR;
   assign c_time = (c_off[31:3] == 29'd0);
   assign c_cmp  = (c_off[31:3] == 29'd1);
   assign c_ok   = (c_len == 8'd0) && (c_time || c_cmp);

   assign wr_time = commit && c_ok && c_time;

   always_comb begin
      c_mask = '0;
      for (int i = 0; i < 8; i++) begin
         c_mask[8*i +: 8] = {8{c_strb[i]}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         aw_id_q   <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
            aw_len_q  <= awlen;
            aw_id_q   <= awid;
         end
         // Non-last beats of a burst are drained without being held.
         if (w_fire) begin
            w_held   <= wlast;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bresp <= RESP_OKAY;
         bid   <= '0;
      end else if (commit) begin
         bresp <= c_ok ? RESP_OKAY : RESP_SLVERR;
         bid   <= c_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
      end else begin
         w_state <= w_next;
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (commit) w_next = W_RESP;
         W_RESP:  if (bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Timer registers
   // ------------------------------------------------------------------
   // A software write to mtime wins over a tick; presc keeps running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         mtime <= '0;
      end else begin
         presc <= tick ? 32'd0 : presc + 32'd1;
         if (wr_time) begin
            mtime <= (mtime & ~c_mask) | (c_data & c_mask);
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end
      end
   end

`ifdef CLINT_MTIP_EN
   logic [63:0] mtimecmp;
   logic        wr_cmp;
   logic        mtip_q;

   assign wr_cmp = commit && c_ok && c_cmp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtimecmp <= '1;
      end else if (wr_cmp) begin
         mtimecmp <= (mtimecmp & ~c_mask) | (c_data & c_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtip_q <= 1'b0;
      end else begin
         mtip_q <= (mtime >= mtimecmp);
      end
   end

   assign mtip = mtip_q;
`else
   assign mtip = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------
   r_state_t    r_state;
   r_state_t    r_next;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic        ar_fire;
   logic        r_fire;
   logic        r_done;
   logic [31:0] r_off;
   logic        r_time;
   logic        r_cmp;
   logic        r_ok;
   logic [63:0] r_sel;

   assign arready = (r_state == R_IDLE);
   assign rvalid  = (r_state == R_DATA);

   assign ar_fire = arvalid && arready;
   assign r_fire  = rvalid && rready;
   assign r_done  = r_fire && (r_beat == r_len);

   assign r_off  = araddr - BASE_ADDR;
   assign r_time = (r_off[31:3] == 29'd0);
   assign r_cmp  = (r_off[31:3] == 29'd1);
   assign r_ok   = (arlen == 8'd0) && (r_time || r_cmp);

   // Sampled from the current flops, so a same-cycle write is not seen.
   always_comb begin
      r_sel = '0;
      if (r_time) begin
         r_sel = mtime;
      end
`ifdef CLINT_MTIP_EN
      else if (r_cmp) begin
         r_sel = mtimecmp;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rid    <= '0;
         r_len  <= '0;
         r_beat <= '0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
         rlast  <= 1'b0;
      end else if (ar_fire) begin
         rid    <= arid;
         r_len  <= arlen;
         r_beat <= '0;
         rdata  <= r_ok ? r_sel : 64'd0;
         rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
         rlast  <= (arlen == 8'd0);
      end else if (r_fire) begin
         r_beat <= r_beat + 8'd1;
         rlast  <= (r_beat + 8'd1 == r_len);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
      end else begin
         r_state <= r_next;
      end
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_fire) r_next = R_DATA;
         R_DATA:  if (r_done) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Burst type/size are not needed: only single 64-bit beats are served.
   logic unused;
   assign unused = ^{awsize, awburst, arsize, arburst,
                     c_off[2:0], r_off[2:0]};

endmodule
